// File: rtl/wavelet_readout_rx.sv
// wavelet_readout_rx: synchronises I/Q feedback streams, integrates fixed windows, buffers {I,Q,seq} results
module wavelet_readout_rx #(
  parameter int WIN_LOG2 = 8,
  parameter int SYNC_STAGES = 2,
  localparam int ACC_W = WIN_LOG2 + 2
) (
  input  logic                    clk_master,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    div2out,
  input  logic [1:0]              read_out_I,
  input  logic [1:0]              read_out_Q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_I,
  output logic signed [ACC_W-1:0] out_Q,
  output logic [3:0]              out_seq,
  output logic                    overflow,
  output logic                    illegal,
  input  logic                    clear_flags
);
  localparam int E_W = 2 * ACC_W + 4;
  typedef enum logic [1:0] {IDLE, ARM, ACCUM} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic div_prev_q;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d, dec_i, dec_q, sum_i, sum_q;
  logic [3:0] seq_q;
  logic [E_W-1:0] head_q, tail_q, entry;
  logic [1:0] fill_q;
  logic overflow_q, illegal_q;
  logic [4:0] s;
  logic pulse, acc_en, done, pop, push, drop, bad, clr;
  // strobe and data share one chain so they stay aligned
  assign s = sync_q[SYNC_STAGES-1];
  assign pulse = s[4] & ~div_prev_q;
  assign dec_i = s[3:2] == 2'b01 ? ACC_W'(1) : s[3:2] == 2'b10 ? '1 : '0;
  assign dec_q = s[1:0] == 2'b01 ? ACC_W'(1) : s[1:0] == 2'b10 ? '1 : '0;
  assign sum_i = acc_i_q + dec_i;
  assign sum_q = acc_q_q + dec_q;
  assign acc_en = en & (state_q == ACCUM) & pulse;
  assign done = acc_en & (&cnt_q);
  assign bad = acc_en & ((&s[3:2]) | (&s[1:0]));
  assign out_valid = fill_q != 2'd0;
  assign pop = out_valid & out_ready;
  assign push = done & (fill_q != 2'd2 | pop);
  assign drop = done & ~push;
  assign entry = {sum_i, sum_q, seq_q};
  assign clr = !en || state_q != ACCUM || done;
  assign out_I = head_q[E_W-1 -: ACC_W];
  assign out_Q = head_q[4 +: ACC_W];
  assign out_seq = head_q[3:0];
  assign overflow = overflow_q;
  assign illegal = illegal_q;
  always_comb begin
    state_d = !en ? IDLE : state_q == IDLE ? ARM : (state_q == ARM && pulse) ? ACCUM : state_q;
    cnt_d = (!en || state_q != ACCUM) ? '0 : acc_en ? cnt_q + 1'b1 : cnt_q;
    acc_i_d = clr ? '0 : acc_en ? sum_i : acc_i_q;
    acc_q_d = clr ? '0 : acc_en ? sum_q : acc_q_q;
  end
  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q <= '0;
      div_prev_q <= 1'b0;
      cnt_q <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      seq_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      overflow_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[SYNC_STAGES-2:0], div2out, read_out_I, read_out_Q};
      div_prev_q <= s[4];
      cnt_q <= cnt_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      seq_q <= seq_q + 4'(done);
      fill_q <= fill_q + 2'(push) - 2'(pop);
      if ((push && (fill_q == 2'd0 || (pop && fill_q == 2'd1))) || (pop && fill_q == 2'd2))
        head_q <= (pop && fill_q == 2'd2) ? tail_q : entry;
      if (push && ((fill_q == 2'd1 && !pop) || (fill_q == 2'd2 && pop)))
        tail_q <= entry;
      overflow_q <= drop | (overflow_q & ~clear_flags);
      illegal_q <= bad | (illegal_q & ~clear_flags);
    end
  end
endmodule

// File: tb/tb_wavelet_readout_rx.sv
// tb_wavelet_readout_rx: random and directed stimulus against a window-level reference model
module tb_wavelet_readout_rx;
  localparam int WL = 2, SS = 2, AW = WL + 2, N = 1 << WL;
  logic clk = 0, rst = 1, en = 0, div2out = 0, out_ready = 0, clear_flags = 0;
  logic [1:0] read_out_I = 0, read_out_Q = 0;
  logic out_valid, overflow, illegal;
  logic signed [AW-1:0] out_I, out_Q;
  logic [3:0] out_seq;
  int tests = 0, fails = 0;
  int rdy_lvl;

  always #5 clk = ~clk;

  wavelet_readout_rx #(.WIN_LOG2(WL), .SYNC_STAGES(SS)) dut (
    .clk_master(clk), .rst(rst), .en(en), .div2out(div2out),
    .read_out_I(read_out_I), .read_out_Q(read_out_Q),
    .out_valid(out_valid), .out_ready(out_ready), .out_I(out_I), .out_Q(out_Q),
    .out_seq(out_seq), .overflow(overflow), .illegal(illegal), .clear_flags(clear_flags)
  );

  typedef struct {int i; int q; int s;} res_t;
  res_t exp_q[$];
  int win_i[$], win_q[$];
  int m_mode, m_seq;
  bit m_ovf, m_ill;
  bit [4:0] h[SS+1];

  function automatic int dec(bit [1:0] p);
    return p == 2'b01 ? 1 : p == 2'b10 ? -1 : 0;
  endfunction

  task automatic chk(string n, int a, int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  // reference: a sample is the synchronised strobe's rising edge; windows are lists of N decoded samples
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete(); win_i.delete(); win_q.delete();
      m_mode = 0; m_seq = 0; m_ovf = 0; m_ill = 0;
      for (int k = 0; k <= SS; k++) h[k] = 0;
    end else begin
      bit smp, pop, done, ill, ovf;
      res_t r;
      smp = h[SS-1][4] && !h[SS][4];
      pop = exp_q.size() > 0 && out_ready;
      done = 0; ill = 0; ovf = 0;
      if (!en) begin
        m_mode = 0; win_i.delete(); win_q.delete();
      end else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
        if (smp) begin m_mode = 2; win_i.delete(); win_q.delete(); end
      end else if (smp) begin
        win_i.push_back(dec(h[SS-1][3:2]));
        win_q.push_back(dec(h[SS-1][1:0]));
        ill = h[SS-1][3:2] == 2'b11 || h[SS-1][1:0] == 2'b11;
        if (win_i.size() == N) begin
          done = 1; r.i = 0; r.q = 0; r.s = m_seq;
          foreach (win_i[k]) begin r.i += win_i[k]; r.q += win_q[k]; end
          m_seq = (m_seq + 1) % 16;
          win_i.delete(); win_q.delete();
        end
      end
      if (pop) void'(exp_q.pop_front());
      if (done) begin
        if (exp_q.size() < 2) exp_q.push_back(r);
        else ovf = 1;
      end
      m_ovf = ovf | (m_ovf & !clear_flags);
      m_ill = ill | (m_ill & !clear_flags);
      for (int k = SS; k > 0; k--) h[k] = h[k-1];
      h[0] = {div2out, read_out_I, read_out_Q};
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk("out_I", out_I, exp_q[0].i);
        chk("out_Q", out_Q, exp_q[0].q);
        chk("out_seq", out_seq, exp_q[0].s);
      end
      chk("overflow", overflow, m_ovf);
      chk("illegal", illegal, m_ill);
    end
  end

  task automatic sample(input bit [1:0] i, input bit [1:0] q);
    @(negedge clk);
    read_out_I = i; read_out_Q = q; div2out = 1;
    repeat (2) @(negedge clk);
    div2out = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pop1();
    @(negedge clk); out_ready = 1;
    @(negedge clk); out_ready = 0;
  endtask

  task automatic wait_valid(string n);
    int k = 0;
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    chk(n, out_valid, 1);
  endtask

  task automatic clear();
    @(negedge clk); clear_flags = 1;
    @(negedge clk); clear_flags = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0); chk("rst_I", out_I, 0); chk("rst_Q", out_Q, 0);
    chk("rst_seq", out_seq, 0); chk("rst_ovf", overflow, 0); chk("rst_ill", illegal, 0);
    rst = 0; en = 1;
    repeat (2) @(negedge clk);
    // ARM sample then a full window of I=+1, Q=-1
    repeat (4) sample(2'b01, 2'b10);
    @(negedge clk); read_out_I = 2'b01; read_out_Q = 2'b10; div2out = 1;
    repeat (2) @(negedge clk);
    chk("lat_early", out_valid, 0);
    div2out = 0;
    @(negedge clk);
    chk("lat_valid", out_valid, 1); chk("lat_I", out_I, 4); chk("lat_Q", out_Q, -4); chk("lat_seq", out_seq, 0);
    @(negedge clk);
    pop1();
    // mixed I, Q held illegal
    sample(2'b01, 2'b11); sample(2'b10, 2'b11); sample(2'b00, 2'b11); sample(2'b01, 2'b11);
    wait_valid("w2_valid");
    chk("w2_I", out_I, 1); chk("w2_Q", out_Q, 0); chk("w2_seq", out_seq, 1); chk("w2_ill", illegal, 1);
    clear();
    chk("ill_clear", illegal, 0);
    pop1();
    // three windows with no consumer
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    sample(2'b00, 2'b00);
    repeat (12) sample(2'b01, 2'b00);
    chk("full_valid", out_valid, 1); chk("full_seq0", out_seq, 0); chk("full_I", out_I, 4); chk("ovf_set", overflow, 1);
    pop1(); chk("drain_seq1", out_seq, 1);
    pop1(); chk("drain_empty", out_valid, 0);
    repeat (4) sample(2'b01, 2'b00);
    wait_valid("w_after_valid");
    chk("w_after_seq", out_seq, 3);
    pop1();
    // push into a full buffer in the same cycle as a pop
    clear();
    chk("ovf_clear", overflow, 0);
    repeat (8) sample(2'b10, 2'b01);
    repeat (3) sample(2'b00, 2'b01);
    @(negedge clk); read_out_I = 2'b00; read_out_Q = 2'b01; div2out = 1;
    @(negedge clk);
    @(negedge clk); out_ready = 1;
    @(negedge clk); out_ready = 0; div2out = 0;
    chk("pp_ovf", overflow, 0); chk("pp_valid", out_valid, 1); chk("pp_seq", out_seq, 5);
    @(negedge clk);
    pop1(); chk("pp_seq6", out_seq, 6); chk("pp_I6", out_I, 0); chk("pp_Q6", out_Q, 4);
    pop1(); chk("pp_empty", out_valid, 0);
    // partial window discarded by en drop
    repeat (2) sample(2'b01, 2'b00);
    @(negedge clk); en = 0;
    repeat (3) @(negedge clk);
    en = 1;
    repeat (2) @(negedge clk);
    sample(2'b01, 2'b00);
    repeat (4) sample(2'b10, 2'b01);
    wait_valid("en_valid");
    chk("en_I", out_I, -4); chk("en_Q", out_Q, 4); chk("en_seq", out_seq, 7);
    pop1();
    // async reset with a result pending and a window half done
    repeat (4) sample(2'b01, 2'b01);
    wait_valid("ar_pre");
    repeat (2) sample(2'b01, 2'b01);
    @(negedge clk); #2 rst = 1; #1;
    chk("ar_valid", out_valid, 0); chk("ar_I", out_I, 0); chk("ar_Q", out_Q, 0);
    chk("ar_seq", out_seq, 0); chk("ar_ovf", overflow, 0); chk("ar_ill", illegal, 0);
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);
    sample(2'b00, 2'b00);
    repeat (4) sample(2'b01, 2'b10);
    wait_valid("ar_post");
    chk("ar_post_seq", out_seq, 0); chk("ar_post_I", out_I, 4); chk("ar_post_Q", out_Q, -4);
    pop1();
    // random traffic against the model
    rdy_lvl = 4;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 200 == 0) rdy_lvl = $urandom_range(0, 8);
      div2out = 1'($urandom);
      read_out_I = 2'($urandom);
      read_out_Q = 2'($urandom);
      out_ready = $urandom_range(0, 7) < rdy_lvl;
      clear_flags = $urandom_range(0, 19) == 0;
      en = $urandom_range(0, 99) != 0;
    end
    @(negedge clk); en = 1; out_ready = 0; clear_flags = 0; div2out = 0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
